// File: rtl/shift_frame_sequencer_if.sv
// Bundle of frame-control inputs and shift-chain outputs between the channel
// generators (master) and the frame sequencer (slave).
interface shift_frame_sequencer_if;
   logic        en;
   logic        start;
   logic [63:0] top;
   logic        busy;
   logic        frame_done;
   logic        overrun;
   logic        latch;
   logic        clock;
   logic [7:0]  data;

   modport master (
      output en, start, top,
      input  busy, frame_done, overrun, latch, clock, data
   );

   modport slave (
      input  en, start, top,
      output busy, frame_done, overrun, latch, clock, data
   );
endinterface

// File: rtl/shift_frame_sequencer.sv
// Shifts a 64-bit channel snapshot MSB-first into eight 8-bit latching shift
// lanes, one frame per start pulse or auto frame tick.
module shift_frame_sequencer #(
   parameter int HALF_PERIOD  = 4,
   parameter int LATCH_CYCLES = 2,
   parameter int FRAME_DIV    = 2000
) (
   input logic                     clk,
   input logic                     rst,
   shift_frame_sequencer_if.slave  bus
);

   localparam int TW   = $clog2(FRAME_DIV);
   localparam int PMAX = (HALF_PERIOD > LATCH_CYCLES) ? HALF_PERIOD : LATCH_CYCLES;
   localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;

   typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH} state_t;

   state_t        state_q;
   logic [TW-1:0] tick_cnt_q;
   logic [PW-1:0] phase_q;
   logic [2:0]    idx_q;
   logic [63:0]   snap_q;
   logic          pending_q;
   logic          busy_q, frame_done_q, overrun_q, latch_q, clock_q;
   logic [7:0]    data_q;
   logic          tick, trigger;

   // Lane k carries byte k of the vector; bit index i selects bit 7-i of that byte.
   function automatic logic [7:0] lane_bits(input logic [63:0] v, input logic [2:0] i);
      logic [7:0] r;
      r = '0;
      for (int k = 0; k < 8; k++) r[k] = v[{3'(k), ~i}];
      return r;
   endfunction

   assign tick    = bus.en && (tick_cnt_q == TW'(FRAME_DIV - 1));
   assign trigger = bus.start | tick;

   always_ff @(posedge clk) begin
      if (rst || !bus.en) tick_cnt_q <= '0;
      else if (tick)      tick_cnt_q <= '0;
      else                tick_cnt_q <= tick_cnt_q + 1'b1;
   end

   // NOTE: every register in this block uses <= so all next values are computed
   // from the same pre-edge state; outputs are set for the state being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         phase_q      <= '0;
         idx_q        <= '0;
         snap_q       <= '0;
         pending_q    <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         overrun_q    <= 1'b0;
         latch_q      <= 1'b0;
         clock_q      <= 1'b0;
         data_q       <= '0;
      end else begin
         frame_done_q <= 1'b0;
         overrun_q    <= 1'b0;
         if (state_q != IDLE && trigger) begin
            if (pending_q) overrun_q <= 1'b1;
            else           pending_q <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (trigger || pending_q) begin
                  state_q   <= LOAD;
                  pending_q <= 1'b0;
                  busy_q    <= 1'b1;
               end
            end
            LOAD: begin
               snap_q  <= bus.top;
               idx_q   <= '0;
               phase_q <= '0;
               data_q  <= lane_bits(bus.top, 3'd0);
               state_q <= SHIFT_LO;
            end
            SHIFT_LO: begin
               if (phase_q == PW'(HALF_PERIOD - 1)) begin
                  phase_q <= '0;
                  clock_q <= 1'b1;
                  state_q <= SHIFT_HI;
               end else begin
                  phase_q <= phase_q + 1'b1;
               end
            end
            SHIFT_HI: begin
               if (phase_q == PW'(HALF_PERIOD - 1)) begin
                  phase_q <= '0;
                  clock_q <= 1'b0;
                  if (idx_q == 3'd7) begin
                     latch_q <= 1'b1;
                     state_q <= LATCH;
                  end else begin
                     idx_q   <= idx_q + 3'd1;
                     data_q  <= lane_bits(snap_q, idx_q + 3'd1);
                     state_q <= SHIFT_LO;
                  end
               end else begin
                  phase_q <= phase_q + 1'b1;
               end
            end
            LATCH: begin
               if (phase_q == PW'(LATCH_CYCLES - 1)) begin
                  phase_q      <= '0;
                  latch_q      <= 1'b0;
                  busy_q       <= 1'b0;
                  data_q       <= '0;
                  frame_done_q <= 1'b1;
                  state_q      <= IDLE;
               end else begin
                  phase_q <= phase_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy       = busy_q;
   assign bus.frame_done = frame_done_q;
   assign bus.overrun    = overrun_q;
   assign bus.latch      = latch_q;
   assign bus.clock      = clock_q;
   assign bus.data       = data_q;

endmodule
